// File: rtl/alarm_controller.sv
// Keypad/alarm control FSM for a digital alarm clock: sequences digit entry,
// time/alarm loads, alarm display and entry timeout.
module alarm_controller #(
   parameter int TIMEOUT_SEC = 10,
   parameter int DIGITS      = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       one_second,
   input  logic       key_valid,
   input  logic       alarm_button,
   input  logic       time_button,
   output logic       shift,
   output logic       show_new_time,
   output logic       show_alarm,
   output logic       load_new_alarm,
   output logic       load_new_time,
   output logic       reset_count,
   output logic [2:0] digit_count
);

   localparam int              TW           = $clog2(TIMEOUT_SEC + 1);
   localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(TIMEOUT_SEC - 1);
   localparam logic [2:0]      DIGITS_MAX   = 3'(DIGITS);

   typedef enum logic [2:0] {
      SHOW_TIME,
      KEY_STORED,
      KEY_WAIT,
      KEY_ENTRY,
      SHOW_ALARM,
      SET_ALARM_TIME,
      SET_CURRENT_TIME
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [TW-1:0] timeout_count;
   logic          timeout;
   logic          entry_full;

   assign entry_full = (digit_count == DIGITS_MAX);

   // The timeout fires on the pulse that would take the counter to TIMEOUT_SEC.
   always_comb begin
      timeout = 1'b0;
      if ((state == KEY_WAIT || state == KEY_ENTRY) && one_second &&
          timeout_count == TIMEOUT_LAST)
         timeout = 1'b1;
   end

   always_comb begin
      state_next = state;
      case (state)
         SHOW_TIME: begin
            if (alarm_button)   state_next = SHOW_ALARM;
            else if (key_valid) state_next = KEY_STORED;
         end
         SHOW_ALARM: begin
            if (!alarm_button) state_next = SHOW_TIME;
         end
         KEY_STORED: state_next = KEY_WAIT;
         KEY_WAIT: begin
            if (timeout)         state_next = SHOW_TIME;
            else if (!key_valid) state_next = KEY_ENTRY;
         end
         KEY_ENTRY: begin
            if (timeout)           state_next = SHOW_TIME;
            else if (alarm_button) state_next = entry_full ? SET_ALARM_TIME : SHOW_TIME;
            else if (time_button)  state_next = entry_full ? SET_CURRENT_TIME : SHOW_TIME;
            else if (key_valid)    state_next = KEY_STORED;
         end
         SET_ALARM_TIME:   state_next = SHOW_TIME;
         SET_CURRENT_TIME: state_next = SHOW_TIME;
         default:          state_next = SHOW_TIME;
      endcase
   end

   // Outputs are registered from the next state so they line up exactly with
   // the state register and never see the inputs combinationally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= SHOW_TIME;
         timeout_count  <= '0;
         digit_count    <= '0;
         shift          <= 1'b0;
         show_new_time  <= 1'b0;
         show_alarm     <= 1'b0;
         load_new_alarm <= 1'b0;
         load_new_time  <= 1'b0;
         reset_count    <= 1'b0;
      end else begin
         state          <= state_next;
         shift          <= (state_next == KEY_STORED);
         show_new_time  <= (state_next == KEY_STORED) || (state_next == KEY_WAIT) ||
                           (state_next == KEY_ENTRY);
         show_alarm     <= (state_next == SHOW_ALARM);
         load_new_alarm <= (state_next == SET_ALARM_TIME);
         load_new_time  <= (state_next == SET_CURRENT_TIME);
         reset_count    <= (state_next == SET_CURRENT_TIME);

         if ((state == KEY_WAIT || state == KEY_ENTRY) && one_second && !timeout)
            timeout_count <= timeout_count + 1'b1;
         else if (state != KEY_WAIT && state != KEY_ENTRY)
            timeout_count <= '0;

         if (state == KEY_STORED && digit_count < DIGITS_MAX)
            digit_count <= digit_count + 3'd1;
         else if (state == SHOW_TIME || state == SHOW_ALARM)
            digit_count <= '0;
      end
   end

endmodule
